// File: rtl/regfile_arbiter_if.sv
// Request/response bundle between the bus-side agents and regfile_arbiter.
// The arbiter takes the slave modport; the agents (or a bench) take master.
interface regfile_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int ADDR  = 4,
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  // A beat transfers on any cycle where valid and ready are both high at the
  // rising clock edge. Once valid is high, the response fields are held
  // stable until ready accepts them.
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ-1:0]       req_we;
  logic [N_REQ*ADDR-1:0]  req_addr;
  logic [N_REQ*WIDTH-1:0] req_wdata;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [WIDTH-1:0]       rsp_rdata;
  logic                   rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/regfile_arbiter.sv
// Round-robin arbiter sharing one single-port register file among N_REQ agents.
// Define REGFILE_ARB_STATS_EN to build per-requester saturating grant counters.
module regfile_arbiter #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int ADDR  = 4,
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_arbiter_if.slave      bus,
  output logic                  rf_wr_en,
  output logic                  rf_rd_en,
  output logic [ADDR-1:0]       rf_addr,
  output logic [WIDTH-1:0]      rf_wdata,
  input  logic [WIDTH-1:0]      rf_rdata,
  output logic [N_REQ*16-1:0]   stat_grant_cnt,
  output logic [1:0]            o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RDWAIT = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t           r_state;
  logic [ID_W-1:0]  r_last;
  logic [ID_W-1:0]  r_id;
  logic             r_we;
  logic             r_err;
  logic             r_rf_wr_en;
  logic             r_rf_rd_en;
  logic [ADDR-1:0]  r_rf_addr;
  logic [WIDTH-1:0] r_rf_wdata;
  logic             r_rsp_valid;
  logic [ID_W-1:0]  r_rsp_id;
  logic [WIDTH-1:0] r_rsp_rdata;
  logic             r_rsp_err;

  logic             w_grant_vld;
  logic [ID_W-1:0]  w_grant_id;
  logic [ID_W:0]    w_idx;
  logic             w_sel_we;
  logic [ADDR-1:0]  w_sel_addr;
  logic [WIDTH-1:0] w_sel_wdata;
  logic             w_sel_err;
  logic             w_hs;

  // Scan from farthest to nearest so the requester just after r_last wins.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_id  = '0;
    w_idx       = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      w_idx = {1'b0, r_last} + (ID_W+1)'(k);
      if (w_idx >= (ID_W+1)'(N_REQ)) w_idx = w_idx - (ID_W+1)'(N_REQ);
      if (bus.req_valid[w_idx[ID_W-1:0]]) begin
        w_grant_vld = 1'b1;
        w_grant_id  = w_idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant_id == ID_W'(i)) begin
        w_sel_we    = bus.req_we[i];
        w_sel_addr  = bus.req_addr[i*ADDR +: ADDR];
        w_sel_wdata = bus.req_wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_sel_err = ({1'b0, w_sel_addr} >= (ADDR+1)'(DEPTH));
  assign w_hs      = (r_state == S_IDLE) && w_grant_vld;

  assign bus.req_ready = w_hs ? (N_REQ'(1) << w_grant_id) : '0;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;
  assign rf_wr_en      = r_rf_wr_en;
  assign rf_rd_en      = r_rf_rd_en;
  assign rf_addr       = r_rf_addr;
  assign rf_wdata      = r_rf_wdata;
  assign o_dbg_state   = r_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_last      <= ID_W'(N_REQ-1);
      r_id        <= '0;
      r_we        <= 1'b0;
      r_err       <= 1'b0;
      r_rf_wr_en  <= 1'b0;
      r_rf_rd_en  <= 1'b0;
      r_rf_addr   <= '0;
      r_rf_wdata  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_vld) begin
            r_id       <= w_grant_id;
            r_last     <= w_grant_id;
            r_we       <= w_sel_we;
            r_err      <= w_sel_err;
            r_rf_addr  <= w_sel_addr;
            r_rf_wdata <= w_sel_wdata;
            // Enables are set here so they are registered high exactly in ACCESS.
            r_rf_wr_en <= w_sel_we & ~w_sel_err;
            r_rf_rd_en <= ~w_sel_we & ~w_sel_err;
            r_state    <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          r_rf_wr_en <= 1'b0;
          r_rf_rd_en <= 1'b0;
          r_rf_addr  <= '0;
          r_rf_wdata <= '0;
          if (r_err || r_we) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_id;
            r_rsp_err   <= r_err;
            r_rsp_rdata <= '0;
            r_state     <= S_RESP;
          end else begin
            r_state <= S_RDWAIT;
          end
        end
        S_RDWAIT: begin
          r_rsp_valid <= 1'b1;
          r_rsp_id    <= r_id;
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= rf_rdata;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef REGFILE_ARB_STATS_EN
  logic [15:0] r_grant_cnt [N_REQ];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_REQ; i++) r_grant_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (w_hs && (w_grant_id == ID_W'(i)) && (r_grant_cnt[i] != 16'hFFFF))
          r_grant_cnt[i] <= r_grant_cnt[i] + 16'd1;
      end
    end
  end

  always_comb begin
    stat_grant_cnt = '0;
    for (int i = 0; i < N_REQ; i++) stat_grant_cnt[i*16 +: 16] = r_grant_cnt[i];
  end
`else
  assign stat_grant_cnt = '0;
`endif

endmodule

// File: doc/regfile_arbiter.md
Name: regfile_arbiter

Overview:
- Shares the single-port register file (WIDTH x DEPTH, separate write and read enables, registered read data) between N_REQ requesters.
- Each requester issues read or write transactions over a valid/ready request channel and gets a valid/ready response.
- Round-robin arbitration; one transaction in flight at a time.
- Sits between bus-side agents (CPU/config master, DMA, test port) and the register file instance.

Parameters:
- WIDTH, 32, data width; must match the register file.
- DEPTH, 16, number of registers.
- ADDR, 4, address width.
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester index width, equal to clog2(N_REQ).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester accept; one-hot or zero.
- req_we  in  N_REQ  1 = write, 0 = read.
- req_addr  in  N_REQ*ADDR  packed addresses; requester i at slice [i*ADDR +: ADDR].
- req_wdata  in  N_REQ*WIDTH  packed write data.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  ID_W  index of the requester being answered.
- rsp_rdata  out  WIDTH  read data; 0 for writes and errors.
- rsp_err  out  1  address >= DEPTH; no register file access made.
- rf_wr_en  out  1  to register file WrEn.
- rf_rd_en  out  1  to register file RdEn.
- rf_addr  out  ADDR  to register file Address.
- rf_wdata  out  WIDTH  to register file WrData.
- rf_rdata  in  WIDTH  from register file RdData; valid the cycle after rf_rd_en.
- stat_grant_cnt  out  N_REQ*16  per-requester grant counters (Optional Feature).

Behaviour:
- Reset (rst low, async): state IDLE, all outputs 0, round-robin pointer last = N_REQ-1, so requester 0 wins first.
- FSM states: IDLE, ACCESS, RDWAIT, RESP.
- IDLE:
  - Grant the first requester with valid set, searching from last+1 upward with wrap.
  - req_ready[grant] is high combinationally in the same cycle; the handshake is that cycle.
  - Latch id, we, addr, wdata; set last = grant. Next state ACCESS.
  - No valid set: stay in IDLE, req_ready = 0.
- ACCESS, exactly one cycle; drives rf_addr and rf_wdata from the latches.
  - Address >= DEPTH: no enable asserted, rsp_err = 1, rsp_rdata = 0, go to RESP.
  - Write: rf_wr_en = 1 for this cycle only, go to RESP.
  - Read: rf_rd_en = 1 for this cycle only, go to RDWAIT.
- RDWAIT: register rf_rdata into rsp_rdata at the cycle end, go to RESP.
- RESP:
  - rsp_valid = 1; rsp_id, rsp_rdata and rsp_err are held stable until rsp_ready.
  - On rsp_valid & rsp_ready, go to IDLE; response fields clear to 0.
  - req_ready stays 0 outside IDLE.
- Latency, counted from the request handshake cycle T: write response at T+2; read response at T+3; error response at T+2.
- Minimum issue interval for back-to-back requests with rsp_ready tied high: writes every 3 cycles, reads every 4.
- Invariants:
  - rf_wr_en and rf_rd_en are never high together.
  - Both enables are 0 outside ACCESS.
  - rf_addr and rf_wdata return to 0 outside ACCESS.
- Fairness: a continuously requesting agent is granted within N_REQ arbitrations.
- Requesters may drop valid before being granted; the arbiter makes no request-hold check.
- Reset mid-transaction abandons it. No response is issued, and the register file is reset by the same rst.

Optional Feature:
- Macro REGFILE_ARB_STATS_EN.
- Defined: each requester has a 16-bit counter, incremented on its grant and saturating at 0xFFFF. Counters reset to 0 and appear on stat_grant_cnt, requester i at slice [i*16 +: 16].
- Undefined: stat_grant_cnt is tied to 0 and no counter flops are built.

Test Plan:
- Requester 1 writes addr 3 = 0xDEADBEEF, then reads addr 3 -> write response at T+2 with rsp_id=1 and rsp_err=0; read response at T+3 with rsp_rdata=0xDEADBEEF.
- All 4 requesters hold valid continuously -> grant order 0,1,2,3,0,1; never two req_ready bits high at once.
- rsp_ready held low 5 cycles during a read of 0x12345678 -> rsp_valid and rsp_rdata stable for all 5 cycles; no new grant and no rf enable until the response handshake.
- Read of addr 15 in a 16-deep file, then DEPTH=12 build with a read of addr 13 -> addr 15 returns correct data with rsp_err=0; addr 13 gives rsp_err=1, rsp_rdata=0, and rf_rd_en never asserts.
- rst pulsed low during RDWAIT -> all outputs 0 immediately; next grant goes to requester 0; no stale response.
- With REGFILE_ARB_STATS_EN, 3 grants to requester 2 and 1 to requester 0 -> stat_grant_cnt slice 2 = 3, slice 0 = 1, others 0.
